// File: rtl/mdu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mdu_pkg
// Brief    : Shared definitions for the multiply/divide unit: op encodings,
//            operation latencies, FSM state type and a latency helper.
// Revision : 1.0 - initial release
// ============================================================================
package mdu_pkg;

    // Operation encodings presented on the op input
    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    // Busy cycles from the accepting edge to the result edge
    localparam logic [3:0] MULT_LAT = 4'd5;
    localparam logic [3:0] DIV_LAT  = 4'd10;

    // Two-state controller
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    // Latency to load into the down-counter for a multiply/divide op
    function automatic logic [3:0] op_latency(input logic [2:0] op_in);
        return (op_in == OP_DIV || op_in == OP_DIVU) ? DIV_LAT : MULT_LAT;
    endfunction

endpackage : mdu_pkg
`default_nettype wire

// File: rtl/mdu.sv
`default_nettype none
// ============================================================================
// Module   : mdu
// Brief    : Multi-cycle HI/LO multiply/divide unit. Operands are latched at
//            the accepting edge, the result is computed combinationally from
//            the latched copies and captured into HI/LO when the counter
//            expires. MTHI/MTLO write HI/LO directly while idle.
// Revision : 1.0 - initial release
// ============================================================================
module mdu
    import mdu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic [2:0]  r_op;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic        r_busy;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    // Products: operands widened to 64 bits so the low 64 bits are exact
    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;

    // Division: signed division is done on magnitudes so that the
    // 0x80000000 / -1 overflow case wraps cleanly to 0x80000000 rem 0
    logic        w_a_neg;
    logic        w_b_neg;
    logic        w_b_zero;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [31:0] w_div_s;
    logic [31:0] w_div_u;
    logic [31:0] w_q_mag;
    logic [31:0] w_r_mag;
    logic [31:0] w_q_s;
    logic [31:0] w_r_s;
    logic [31:0] w_q_u;
    logic [31:0] w_r_u;

    assign w_prod_s = {{32{r_a[31]}}, r_a} * {{32{r_b[31]}}, r_b};
    assign w_prod_u = {32'd0, r_a} * {32'd0, r_b};

    assign w_a_neg  = r_a[31];
    assign w_b_neg  = r_b[31];
    assign w_b_zero = (r_b == 32'd0);
    assign w_a_mag  = w_a_neg ? (~r_a + 32'd1) : r_a;
    assign w_b_mag  = w_b_neg ? (~r_b + 32'd1) : r_b;

    // Divisors forced non-zero; a zero-divisor result is discarded anyway
    assign w_div_s  = w_b_zero ? 32'd1 : w_b_mag;
    assign w_div_u  = w_b_zero ? 32'd1 : r_b;

    assign w_q_mag  = w_a_mag / w_div_s;
    assign w_r_mag  = w_a_mag % w_div_s;
    assign w_q_s    = (w_a_neg ^ w_b_neg) ? (~w_q_mag + 32'd1) : w_q_mag;
    assign w_r_s    = w_a_neg ? (~w_r_mag + 32'd1) : w_r_mag;
    assign w_q_u    = r_a / w_div_u;
    assign w_r_u    = r_a % w_div_u;

    assign busy = r_busy;
    assign hi   = r_hi;
    assign lo   = r_lo;

    // Controller: accept ops in IDLE, count down in BUSY, capture result at expiry
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
            r_op    <= 3'd0;
            r_a     <= 32'd0;
            r_b     <= 32'd0;
            r_busy  <= 1'b0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        case (op)
                            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                                r_op    <= op;
                                r_a     <= a;
                                r_b     <= b;
                                r_cnt   <= op_latency(op);
                                r_busy  <= 1'b1;
                                r_state <= ST_BUSY;
                            end
                            OP_MTHI: r_hi <= a;
                            OP_MTLO: r_lo <= a;
                            default: ;  // reserved ops leave all state alone
                        endcase
                    end
                end
                ST_BUSY: begin
                    if (r_cnt == 4'd1) begin
                        case (r_op)
                            OP_MULT:  {r_hi, r_lo} <= w_prod_s;
                            OP_MULTU: {r_hi, r_lo} <= w_prod_u;
                            OP_DIV: begin
                                if (!w_b_zero) begin
                                    r_lo <= w_q_s;
                                    r_hi <= w_r_s;
                                end
                            end
                            OP_DIVU: begin
                                if (!w_b_zero) begin
                                    r_lo <= w_q_u;
                                    r_hi <= w_r_u;
                                end
                            end
                            default: ;
                        endcase
                        r_cnt   <= 4'd0;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_cnt   <= 4'd0;
                end
            endcase
        end
    end

endmodule : mdu
`default_nettype wire

// File: tb/tb_mdu.sv
`default_nettype none
// ============================================================================
// Module   : tb_mdu
// Brief    : Directed self-checking bench for the multiply/divide unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mdu;

    localparam logic [2:0] c_MULT  = 3'd0;
    localparam logic [2:0] c_MULTU = 3'd1;
    localparam logic [2:0] c_DIV   = 3'd2;
    localparam logic [2:0] c_DIVU  = 3'd3;
    localparam logic [2:0] c_MTHI  = 3'd4;
    localparam logic [2:0] c_MTLO  = 3'd5;
    localparam int         c_WAIT_MAX = 40;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_total;
    int n_bad;
    int cyc;

    mdu u_dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total = n_total + 1;
        if (obs !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Count edges until busy falls, bounded
    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < c_WAIT_MAX) begin
            tick();
            n = n + 1;
        end
    endtask

    // Issue one op at the next edge and drop start afterwards
    task automatic issue(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv);
        start = 1'b1;
        op    = o;
        a     = av;
        b     = bv;
        tick();
        start = 1'b0;
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        reset   = 1'b1;
        start   = 1'b0;
        op      = 3'd0;
        a       = 32'd0;
        b       = 32'd0;
        tick();
        tick();
        reset = 1'b0;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);

        // Signed multiply -2 * 3
        issue(c_MULT, 32'hFFFF_FFFE, 32'd3);
        check("mult_busy", {31'd0, busy}, 32'd1);
        check("mult_hold_hi", hi, 32'd0);
        check("mult_hold_lo", lo, 32'd0);
        wait_idle(cyc);
        check("mult_lat", cyc, 32'd5);
        check("mult_hi", hi, 32'hFFFF_FFFF);
        check("mult_lo", lo, 32'hFFFF_FFFA);

        // Unsigned multiply 0xFFFFFFFF * 2
        issue(c_MULTU, 32'hFFFF_FFFF, 32'd2);
        wait_idle(cyc);
        check("multu_lat", cyc, 32'd5);
        check("multu_hi", hi, 32'h0000_0001);
        check("multu_lo", lo, 32'hFFFF_FFFE);

        // Signed divide -7 / 2
        issue(c_DIV, 32'hFFFF_FFF9, 32'd2);
        tick();
        check("div_hold_hi", hi, 32'h0000_0001);
        wait_idle(cyc);
        check("div_lat", cyc + 1, 32'd10);
        check("div_lo", lo, 32'hFFFF_FFFD);
        check("div_hi", hi, 32'hFFFF_FFFF);

        // Unsigned divide 7 / 2
        issue(c_DIVU, 32'd7, 32'd2);
        wait_idle(cyc);
        check("divu_lat", cyc, 32'd10);
        check("divu_lo", lo, 32'd3);
        check("divu_hi", hi, 32'd1);

        // Signed overflow case
        issue(c_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle(cyc);
        check("divov_lo", lo, 32'h8000_0000);
        check("divov_hi", hi, 32'd0);

        // MTHI then divide by zero
        issue(c_MTHI, 32'h0000_1234, 32'd0);
        check("mthi_hi", hi, 32'h0000_1234);
        check("mthi_busy", {31'd0, busy}, 32'd0);
        issue(c_DIVU, 32'd99, 32'd0);
        wait_idle(cyc);
        check("div0_lat", cyc, 32'd10);
        check("div0_hi", hi, 32'h0000_1234);
        check("div0_lo", lo, 32'h8000_0000);

        // Reserved op changes nothing
        issue(3'd6, 32'hDEAD_BEEF, 32'd1);
        issue(3'd7, 32'hDEAD_BEEF, 32'd1);
        check("rsv_busy", {31'd0, busy}, 32'd0);
        check("rsv_hi", hi, 32'h0000_1234);
        check("rsv_lo", lo, 32'h8000_0000);

        issue(c_MTLO, 32'h0000_0099, 32'd0);
        check("mtlo_lo", lo, 32'h0000_0099);

        // MTLO during busy is ignored; later operand changes do not leak in
        issue(c_MULT, 32'd3, 32'd5);
        tick();
        start = 1'b1;
        op    = c_MTLO;
        a     = 32'h0000_0055;
        tick();
        start = 1'b0;
        check("ign_lo", lo, 32'h0000_0099);
        check("ign_busy", {31'd0, busy}, 32'd1);
        a = 32'h0000_0077;
        b = 32'd9;
        tick();
        wait_idle(cyc);
        check("ign_lat", cyc + 3, 32'd5);
        check("ign_prod_lo", lo, 32'd15);
        check("ign_prod_hi", hi, 32'd0);

        // Start held through the falling edge of busy: accepted one cycle later
        issue(c_MULT, 32'd2, 32'd3);
        start = 1'b1;
        op    = c_MTHI;
        a     = 32'h0000_00AB;
        wait_idle(cyc);
        check("b2b_lat", cyc, 32'd5);
        check("b2b_hi_exp", hi, 32'd0);
        check("b2b_lo_exp", lo, 32'd6);
        tick();
        start = 1'b0;
        check("b2b_hi_next", hi, 32'h0000_00AB);
        check("b2b_busy", {31'd0, busy}, 32'd0);

        // Reset mid-divide aborts it, and wins over a simultaneous start
        issue(c_DIV, 32'd100, 32'd7);
        tick();
        tick();
        tick();
        reset = 1'b1;
        start = 1'b1;
        op    = c_MTHI;
        a     = 32'h0000_0005;
        tick();
        reset = 1'b0;
        start = 1'b0;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_hi", hi, 32'd0);
        check("abort_lo", lo, 32'd0);
        for (int i = 0; i < 12; i++) tick();
        check("abort_late_busy", {31'd0, busy}, 32'd0);
        check("abort_late_hi", hi, 32'd0);
        check("abort_late_lo", lo, 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_mdu
`default_nettype wire

// File: doc/mdu.md
MDU -- requirements
Module: mdu

Interface
REQ-001 clk  in  1  system clock; all state changes on rising edge.
REQ-002 reset  in  1  synchronous, active-high; clock clk.
REQ-003 start  in  1  request; sampled with op/a/b at rising edge.
REQ-004 op  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6/7 reserved, no effect.
REQ-005 a  in  32  rs operand, register-file read port 1 value.
REQ-006 b  in  32  rt operand, register-file read port 2 value.
REQ-007 busy  out  1  high while a multiply/divide is in flight; upstream stalls on busy.
REQ-008 hi  out  32  HI register, registered output.
REQ-009 lo  out  32  LO register, registered output.

Function
REQ-010 The block SHALL be a two-state FSM (IDLE, BUSY) with a 4-bit down-counter.
REQ-011 In IDLE, start with op 0-3 SHALL latch op/a/b, load the counter with latency, and enter BUSY at that edge.
REQ-012 Latency SHALL be 5 cycles for MULT/MULTU and 10 for DIV/DIVU; busy high for exactly that many cycles after the start edge.
REQ-013 On the edge where the counter expires, hi/lo SHALL update, busy SHALL fall, and the FSM SHALL return to IDLE; hi/lo hold old values during BUSY.
REQ-014 MULT SHALL form the signed 64-bit product {hi,lo}; MULTU the unsigned 64-bit product.
REQ-015 DIV SHALL give lo = signed quotient truncated toward zero, hi = remainder with the dividend's sign; DIVU gives unsigned quotient/remainder.
REQ-016 DIV 0x80000000 / 0xFFFFFFFF SHALL give lo=0x80000000, hi=0.
REQ-017 Divide by zero (b=0) SHALL still occupy 10 busy cycles and SHALL leave hi/lo unchanged.
REQ-018 In IDLE, start with op 4 (MTHI) SHALL write a into hi at that edge; op 5 (MTLO) writes a into lo; busy stays 0.
REQ-019 start while BUSY (any op) SHALL be ignored; operands latched at start SHALL be unaffected by later a/b changes.
REQ-020 start in IDLE with op 6/7 SHALL change no state.
REQ-021 A new start on the same edge busy falls is not accepted (FSM still BUSY); it is accepted the following cycle.

Reset
REQ-022 On reset: FSM to IDLE, counter 0, busy 0, hi 0, lo 0, latched operands 0.
REQ-023 Reset asserted mid-operation SHALL abort it; no hi/lo update from the aborted operation.
REQ-024 Reset SHALL take priority over start on the same edge.

Structure
REQ-025 Shared package mdu_pkg SHALL hold the op encodings, MULT_LAT=5, DIV_LAT=10, and the FSM state type.
REQ-026 Decode stage SHALL reference op encodings only through mdu_pkg.
REQ-027 Single flat module; no sub-module; arithmetic is combinational on latched operands, result captured at expiry.

Verification
REQ-028 MULT a=0xFFFFFFFE (-2), b=3 -> busy high 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-029 MULTU a=0xFFFFFFFF, b=2 -> after 5 cycles hi=0x00000001, lo=0xFFFFFFFE.
REQ-030 DIV a=-7 (0xFFFFFFF9), b=2 -> busy 10 cycles, lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 7/2 -> lo=3, hi=1.
REQ-031 MTHI a=0x1234 then DIVU b=0 -> hi=0x1234 after the 1st edge; after 10 busy cycles hi=0x1234, lo unchanged.
REQ-032 MULT start, MTLO a=0x55 issued at busy cycle 2, a changed at cycle 3 -> MTLO ignored, product uses original a.
REQ-033 DIV start, reset at busy cycle 4 -> busy=0, hi=lo=0 next cycle; no later update.
